// File: rtl/wb_stage_if.sv
// Handshake and writeback bundle between upstream (master) and the writeback stage (slave).
interface wb_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [1:0]            in_sel;
  logic [DATA_WIDTH-1:0] in_alu_res;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [2:0]            in_funct3;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_rd;
  logic                  retire;
  logic [63:0]           instret;
  logic                  err;

  modport master (
    output in_valid, in_rd, in_rd_wen, in_sel, in_alu_res, in_pc, in_funct3,
           mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_rd, rf_data, pend_valid, pend_rd, retire,
           instret, err
  );

  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_sel, in_alu_res, in_pc, in_funct3,
           mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_rd, rf_data, pend_valid, pend_rd, retire,
           instret, err
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: latches one instruction, waits for load data if needed,
// formats the result and writes the register file in a single WRITE cycle.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_rdWen;
  logic [1:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_aluRes;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_loadData;
  logic [63:0]           r_instret;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_inWrite;
  logic                  w_writesReg;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_loadVal;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_ready     = (r_state != WAIT_MEM);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_inWrite   = (r_state == WRITE);
  assign w_writesReg = r_rdWen && (r_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rd       <= '0;
      r_rdWen    <= 1'b0;
      r_sel      <= 2'd0;
      r_aluRes   <= '0;
      r_pc       <= '0;
      r_funct3   <= 3'd0;
      r_loadData <= '0;
      r_instret  <= 64'd0;
    end else begin
      if (r_state == WRITE) begin
        r_instret <= r_instret + 64'd1;
      end
      case (r_state)
        IDLE, WRITE: begin
          if (w_accept) begin
            r_rd     <= bus.in_rd;
            r_rdWen  <= bus.in_rd_wen;
            r_sel    <= bus.in_sel;
            r_aluRes <= bus.in_alu_res;
            r_pc     <= bus.in_pc;
            r_funct3 <= bus.in_funct3;
            r_state  <= (bus.in_sel == 2'd1) ? WAIT_MEM : WRITE;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            r_loadData <= bus.mem_rdata;
            r_state    <= WRITE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte offset moves the addressed element down to bit 0 before sizing.
  assign w_raw = r_loadData >> {r_aluRes[2:0], 3'b000};

  always_comb begin
    w_loadVal = '0;
    case (r_funct3)
      3'b000:  w_loadVal = {{56{w_raw[7]}},  w_raw[7:0]};
      3'b001:  w_loadVal = {{48{w_raw[15]}}, w_raw[15:0]};
      3'b010:  w_loadVal = {{32{w_raw[31]}}, w_raw[31:0]};
      3'b011:  w_loadVal = w_raw;
      3'b100:  w_loadVal = {56'd0, w_raw[7:0]};
      3'b101:  w_loadVal = {48'd0, w_raw[15:0]};
      3'b110:  w_loadVal = {32'd0, w_raw[31:0]};
      default: w_loadVal = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_sel)
      2'd0:    w_result = r_aluRes;
      2'd1:    w_result = w_loadVal;
      2'd2:    w_result = r_pc + DATA_WIDTH'(4);
      default: w_result = '0;
    endcase
  end

  assign bus.in_ready   = w_ready;
  assign bus.rf_wen     = w_inWrite && w_writesReg;
  assign bus.rf_rd      = r_rd;
  assign bus.rf_data    = w_result;
  assign bus.pend_valid = (r_state != IDLE) && w_writesReg;
  assign bus.pend_rd    = r_rd;
  assign bus.retire     = w_inWrite;
  assign bus.instret    = r_instret;
  assign bus.err        = w_inWrite &&
                          ((r_sel == 2'd3) || ((r_sel == 2'd1) && (r_funct3 == 3'b111)));

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized instructions
// compared against a byte-level reference model of the writeback result.
module tb_wb_stage;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;
  logic [63:0] modelInstret;

  wb_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // Reference result assembled byte by byte from the doubleword.
  function automatic logic [63:0] modelData(input logic [1:0] sel, input logic [2:0] f3,
                                            input logic [63:0] alu, input logic [63:0] pc,
                                            input logic [63:0] rdata);
    int nBytes;
    int off;
    logic [63:0] val;
    val = 64'd0;
    case (sel)
      2'd0: val = alu;
      2'd2: val = pc + 64'd4;
      2'd1: begin
        if (f3 != 3'b111) begin
          nBytes = 1 << f3[1:0];
          off    = int'(alu[2:0]);
          for (int b = 0; b < nBytes; b++)
            if (off + b < 8) val[b*8 +: 8] = rdata[(off+b)*8 +: 8];
          if (!f3[2] && nBytes < 8 && val[nBytes*8-1])
            for (int b = nBytes; b < 8; b++) val[b*8 +: 8] = 8'hFF;
        end
      end
      default: val = 64'd0;
    endcase
    return val;
  endfunction

  task automatic scrambleInputs();
    bus.in_rd      = 5'($urandom);
    bus.in_rd_wen  = 1'($urandom);
    bus.in_sel     = 2'($urandom);
    bus.in_alu_res = {$urandom, $urandom};
    bus.in_pc      = {$urandom, $urandom};
    bus.in_funct3  = 3'($urandom);
    bus.mem_rdata  = {$urandom, $urandom};
  endtask

  task automatic driveInstr(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                            input logic [63:0] alu, input logic [63:0] pc,
                            input logic [2:0] f3);
    bus.in_valid   = 1'b1;
    bus.in_rd      = rd;
    bus.in_rd_wen  = wen;
    bus.in_sel     = sel;
    bus.in_alu_res = alu;
    bus.in_pc      = pc;
    bus.in_funct3  = f3;
  endtask

  task automatic checkWrite(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                            input logic [63:0] alu, input logic [63:0] pc,
                            input logic [2:0] f3, input logic [63:0] rdata);
    logic expWen;
    logic expErr;
    expWen = wen && (rd != 5'd0);
    expErr = (sel == 2'd3) || (sel == 2'd1 && f3 == 3'b111);
    checkOutput("retire",     64'(bus.retire), 64'd1);
    checkOutput("rf_wen",     64'(bus.rf_wen), 64'(expWen));
    checkOutput("rf_rd",      64'(bus.rf_rd), 64'(rd));
    checkOutput("rf_data",    bus.rf_data, modelData(sel, f3, alu, pc, rdata));
    checkOutput("err",        64'(bus.err), 64'(expErr));
    checkOutput("pend_valid", 64'(bus.pend_valid), 64'(expWen));
    checkOutput("instret",    bus.instret, modelInstret);
    modelInstret++;
  endtask

  task automatic waitAndReturn(input logic [4:0] rd, input logic wen, input logic [63:0] rdata,
                               input int delay);
    for (int i = 0; i < delay; i++) begin
      checkOutput("stall_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("wait_pend",   64'(bus.pend_valid), 64'(wen && (rd != 5'd0)));
      checkOutput("wait_pend_rd", 64'(bus.pend_rd), 64'(rd));
      checkOutput("wait_retire", 64'(bus.retire), 64'd0);
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = {$urandom, $urandom};
  endtask

  // One isolated instruction from IDLE back to IDLE.
  task automatic applyStimulus(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                               input logic [63:0] alu, input logic [63:0] pc,
                               input logic [2:0] f3, input logic [63:0] rdata,
                               input int delay);
    checkOutput("idle_ready", 64'(bus.in_ready), 64'd1);
    driveInstr(rd, wen, sel, alu, pc, f3);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = {$urandom, $urandom};
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    scrambleInputs();
    if (sel == 2'd1) waitAndReturn(rd, wen, rdata, delay);
    checkWrite(rd, wen, sel, alu, pc, f3, rdata);
    @(negedge clk);
    checkOutput("retire_off", 64'(bus.retire), 64'd0);
    checkOutput("instret_post", bus.instret, modelInstret);
  endtask

  task automatic runThroughput();
    logic [4:0]  tRd[8];
    logic        tWen[8];
    logic [1:0]  tSel[8];
    logic [63:0] tAlu[8];
    logic [63:0] tPc[8];
    logic [63:0] ldData;
    for (int i = 0; i < 8; i++) begin
      tRd[i]  = 5'($urandom);
      tWen[i] = 1'($urandom);
      tSel[i] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
      tAlu[i] = {$urandom, $urandom};
      tPc[i]  = {$urandom, $urandom};
      if (i > 0) checkWrite(tRd[i-1], tWen[i-1], tSel[i-1], tAlu[i-1], tPc[i-1], 3'd0, 64'd0);
      checkOutput("tp_ready", 64'(bus.in_ready), 64'd1);
      driveInstr(tRd[i], tWen[i], tSel[i], tAlu[i], tPc[i], 3'($urandom));
      @(negedge clk);
    end
    checkWrite(tRd[7], tWen[7], tSel[7], tAlu[7], tPc[7], 3'd0, 64'd0);
    checkOutput("tp_ready_ld", 64'(bus.in_ready), 64'd1);
    ldData = {$urandom, $urandom};
    driveInstr(5'd9, 1'b1, 2'd1, 64'h10, 64'h0, 3'b011);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scrambleInputs();
    waitAndReturn(5'd9, 1'b1, ldData, 3);
    checkWrite(5'd9, 1'b1, 2'd1, 64'h10, 64'h0, 3'b011, ldData);
    @(negedge clk);
    checkOutput("tp_retire_off", 64'(bus.retire), 64'd0);
  endtask

  task automatic runResetMidLoad();
    driveInstr(5'd12, 1'b1, 2'd1, 64'h0, 64'h0, 3'b011);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("rst_wait_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    checkOutput("rst_retire", 64'(bus.retire), 64'd0);
    checkOutput("rst_ready",  64'(bus.in_ready), 64'd1);
    checkOutput("rst_pend",   64'(bus.pend_valid), 64'd0);
    checkOutput("rst_instret", bus.instret, 64'd0);
    modelInstret = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    checkOutput("rst_no_retire", 64'(bus.retire), 64'd0);
    checkOutput("rst_no_wen",    64'(bus.rf_wen), 64'd0);
    @(negedge clk);
    checkOutput("rst_instret_hold", bus.instret, 64'd0);
  endtask

  initial begin
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [63:0] alu;
    int          nBytes;
    int          off;
    int          pick;

    nChecks      = 0;
    nFails       = 0;
    modelInstret = 64'd0;
    rst_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    scrambleInputs();

    #2;
    checkOutput("reset_ready",   64'(bus.in_ready), 64'd1);
    checkOutput("reset_rf_wen",  64'(bus.rf_wen), 64'd0);
    checkOutput("reset_retire",  64'(bus.retire), 64'd0);
    checkOutput("reset_err",     64'(bus.err), 64'd0);
    checkOutput("reset_pend",    64'(bus.pend_valid), 64'd0);
    checkOutput("reset_instret", bus.instret, 64'd0);
    checkOutput("reset_rf_data", bus.rf_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(5'd5, 1'b1, 2'd0, 64'h1234, 64'h400, 3'd0, 64'd0, 0);
    applyStimulus(5'd7, 1'b1, 2'd1, 64'h1003, 64'h0, 3'b000, 64'h00000000_80FF0000, 4);
    applyStimulus(5'd8, 1'b1, 2'd1, 64'h2004, 64'h0, 3'b110, 64'hDEADBEEF_00000001, 1);
    applyStimulus(5'd8, 1'b1, 2'd1, 64'h2000, 64'h0, 3'b011, 64'hDEADBEEF_00000001, 0);
    applyStimulus(5'd0, 1'b1, 2'd0, 64'hABCD, 64'h0, 3'd0, 64'd0, 0);
    applyStimulus(5'd1, 1'b1, 2'd2, 64'h0, 64'h80000000, 3'd0, 64'd0, 0);
    applyStimulus(5'd1, 1'b1, 2'd2, 64'h0, 64'hFFFFFFFF_FFFFFFFC, 3'd0, 64'd0, 0);
    applyStimulus(5'd3, 1'b1, 2'd3, 64'h55, 64'h0, 3'd0, 64'd0, 0);
    applyStimulus(5'd4, 1'b1, 2'd1, 64'h0, 64'h0, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 2);

    $display("[TB] throughput");
    runThroughput();

    $display("[TB] randomized instructions");
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 9);
      sel  = (pick < 4) ? 2'd0 : (pick < 7) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      f3   = 3'($urandom);
      rd   = 5'($urandom);
      wen  = 1'($urandom);
      alu  = {$urandom, $urandom};
      if (sel == 2'd1) begin
        nBytes   = 1 << f3[1:0];
        off      = ($urandom_range(0, 7) / nBytes) * nBytes;
        alu[2:0] = 3'(off);
      end
      applyStimulus(rd, wen, sel, alu, {$urandom, $urandom}, f3,
                    {$urandom, $urandom}, $urandom_range(0, 4));
    end

    $display("[TB] reset during load wait");
    runResetMidLoad();
    applyStimulus(5'd6, 1'b1, 2'd0, 64'h77, 64'h0, 3'd0, 64'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
